// File: rtl/audio_clock_synth_if.sv
// Configuration handshake carrying a new phase increment into audio_clock_synth.
`timescale 1ns/1ps
interface audio_clock_synth_if #(
    parameter int ACC_WIDTH = 24
);
    logic [ACC_WIDTH-1:0] cfg_inc;
    logic                 cfg_valid;
    logic                 cfg_ready;

    modport master (output cfg_inc, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_inc, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/audio_clock_synth.sv
// Phase-accumulator audio clock synthesiser: MCLK from accumulator carries,
// BCLK and LRCK divided from it, with a restart/lock state machine.
`timescale 1ns/1ps
module audio_clock_synth #(
    parameter int                   ACC_WIDTH          = 24,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC        = 24'd1342177,
    parameter int                   MCLK_PER_BCLK_HALF = 4,
    parameter int                   BITS_PER_CH        = 32,
    parameter int                   LOCK_MCLKS         = 16
) (
    input  logic                CLOCK_27,
    input  logic                reset_n,
    input  logic                enable,
    audio_clock_synth_if.slave  cfg,
    output logic                AUD_XCK,
    output logic                AUD_BCLK,
    output logic                AUD_LRCK,
    output logic                bclk_fall,
    output logic                lrck_edge,
    output logic                locked
);
    localparam logic [7:0]  MCLK_HALF = 8'(MCLK_PER_BCLK_HALF);
    localparam logic [7:0]  BITS_CH   = 8'(BITS_PER_CH);
    localparam logic [15:0] LOCK_CNT  = 16'(LOCK_MCLKS);

    typedef enum logic [1:0] {STOPPED, APPLY, ACQUIRE, LOCKED} state_t;

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_n_int;
    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] inc_q, inc_d, acc_q, acc_d;
    logic                 xck_q, xck_d, bclk_q, bclk_d, lrck_q, lrck_d;
    logic                 bclk_fall_q, bclk_fall_d, lrck_edge_q, lrck_edge_d;
    logic                 locked_q, locked_d;
    logic [7:0]           mclk_cnt_q, mclk_cnt_d, bit_cnt_q, bit_cnt_d;
    logic [15:0]          lock_cnt_q, lock_cnt_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 accept, mclk_rise;

    // Reset asserts immediately but releases only after two clean clock edges.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_int  = rst_sync_q[1];

    always_ff @(posedge CLOCK_27 or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg.cfg_ready = (state_q != APPLY);

    always_comb begin
        state_d     = state_q;
        inc_d       = inc_q;
        acc_d       = acc_q;
        xck_d       = xck_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        mclk_cnt_d  = mclk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        bclk_fall_d = 1'b0;
        lrck_edge_d = 1'b0;
        mclk_rise   = 1'b0;
        sum         = {1'b0, acc_q} + {1'b0, inc_q};

        // A new increment wins over everything, including a pending lock.
        if (accept || state_q == APPLY) begin
            acc_d      = '0;
            xck_d      = 1'b0;
            bclk_d     = 1'b0;
            lrck_d     = 1'b0;
            mclk_cnt_d = '0;
            bit_cnt_d  = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            if (accept) begin
                inc_d   = cfg.cfg_inc;
                state_d = APPLY;
            end else begin
                state_d = (inc_q != '0) ? ACQUIRE : STOPPED;
            end
        end else if (enable && (state_q == ACQUIRE || state_q == LOCKED)) begin
            acc_d = sum[ACC_WIDTH-1:0];
            if (sum[ACC_WIDTH]) begin
                xck_d     = ~xck_q;
                mclk_rise = ~xck_q;
            end
            if (mclk_rise) begin
                if (mclk_cnt_q + 8'd1 == MCLK_HALF) begin
                    mclk_cnt_d = '0;
                    bclk_d     = ~bclk_q;
                    if (bclk_q) begin
                        bclk_fall_d = 1'b1;
                        if (bit_cnt_q + 8'd1 == BITS_CH) begin
                            bit_cnt_d   = '0;
                            lrck_d      = ~lrck_q;
                            lrck_edge_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    mclk_cnt_d = mclk_cnt_q + 8'd1;
                end
                if (state_q == ACQUIRE) begin
                    lock_cnt_d = lock_cnt_q + 16'd1;
                    if (lock_cnt_q + 16'd1 == LOCK_CNT) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_27 or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= (DEFAULT_INC != '0) ? ACQUIRE : STOPPED;
            inc_q       <= DEFAULT_INC;
            acc_q       <= '0;
            xck_q       <= 1'b0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            mclk_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            bclk_fall_q <= 1'b0;
            lrck_edge_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inc_q       <= inc_d;
            acc_q       <= acc_d;
            xck_q       <= xck_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            mclk_cnt_q  <= mclk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            bclk_fall_q <= bclk_fall_d;
            lrck_edge_q <= lrck_edge_d;
        end
    end

    assign AUD_XCK   = xck_q;
    assign AUD_BCLK  = bclk_q;
    assign AUD_LRCK  = lrck_q;
    assign bclk_fall = bclk_fall_q;
    assign lrck_edge = lrck_edge_q;
    assign locked    = locked_q;
endmodule
